ahb_readback_checker: RTL
=========================

Name: ahb_readback_checker

Overview:
- AHB-Lite read master. After a DMA write completes, it reads back the same RCC-programmed region and checks that the data follows the incrementing pattern.
- Read counterpart of the CPU-side write checker: same RCC_Words_N / RCC_DMA_ADDR_HIGH/LOW / init_data configuration, driven over the bus instead of snooped.
- Sits on a spare master port of the AHB-Lite fabric. Reports mismatch count, first failing address and bus errors to the testbench/CPU model.

Parameters:
ADDR_STEP, 4, byte increment per beat (word transfers only)
BOUNDARY_BYTES, 1024, INCR bursts restart with NONSEQ at multiples of this

Ports:
HCLK  input  1  bus clock; all logic on rising edge
HRESET  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; sampled only in RB_IDLE
RCC_Words_N  input  6  beats to read; 0 = empty job
RCC_DMA_ADDR_HIGH  input  16  base address [31:16]
RCC_DMA_ADDR_LOW  input  16  base address [15:0]
init_data  input  32  expected data of beat 0
HADDR  output  32  address-phase address
HTRANS  output  HTRANS_state  IDLE/NONSEQ/SEQ (BUSY never driven)
HWRITE  output  1  constant 0
HSIZE  output  3  constant 3'b010
HBURST  output  3  constant INCR (3'b001)
HREADY  input  1  transfer complete / stall
HRESP  input  1  0 OKAY, 1 ERROR
HRDATA  input  32  read data
busy  output  1  job in progress
done  output  1  one-cycle pulse at job end
mismatch_cnt  output  6  beats whose data != expected
first_err_addr  output  32  address of first mismatching beat
bus_error  output  1  sticky until next start; ERROR response seen

Behaviour:
- Reset (HRESET=1 at posedge): state RB_IDLE, HTRANS=IDLE, HADDR=0, busy=0, done=0, mismatch_cnt=0, first_err_addr=0, bus_error=0. Reset mid-burst aborts the job immediately. No done pulse is issued.
- Start sampling: start in RB_IDLE latches the base address {HIGH,LOW}, RCC_Words_N and init_data. It also clears mismatch_cnt, first_err_addr and bus_error. start in any other state is ignored.
- Empty job: RCC_Words_N==0 goes to RB_DONE next cycle. No bus transfer is issued.
- States and transitions:
  - RB_IDLE -> RB_XFER on start.
  - RB_XFER: address phase of beat k overlaps the data phase of beat k-1.
  - RB_XFER -> RB_LAST after the final address phase is accepted (HREADY=1).
  - RB_LAST: data phase of the last beat only; HTRANS=IDLE.
  - RB_LAST -> RB_DONE on HREADY=1.
  - RB_DONE: done=1 for one cycle, busy=0, -> RB_IDLE.
- Address sequence: beat 0 is NONSEQ at base. Beat k is at base + k*ADDR_STEP, and is SEQ unless that address mod BOUNDARY_BYTES == 0, in which case it is NONSEQ.
- Stall rule: while HREADY=0, HADDR and HTRANS hold and no counter advances.
- Data check: on HREADY=1 in a data phase of beat k, compare HRDATA with init_data + k (32-bit wrap).
  - On mismatch: mismatch_cnt += 1, saturating at 63.
  - first_err_addr is written on the first mismatch only.
- Beat counting: the address counter and data counter are 6-bit and independent. The data counter lags the address counter by one accepted beat.
- ERROR response:
  - Cycle 1 (HRESP=1, HREADY=0): the master drives HTRANS=IDLE that same cycle, cancelling the pending address phase.
  - Cycle 2 (HRESP=1, HREADY=1): bus_error is set and the job is aborted to RB_DONE. The errored beat is not data-checked.
- busy=1 in RB_XFER, RB_LAST and RB_DONE-entry paths, 0 otherwise. done and busy are registered outputs.

Optional Feature:
RB_STOP_ON_MISMATCH_EN
- Defined: on the first data mismatch the checker drives HTRANS=IDLE in the next address slot. It completes only the already-issued data phase (which is not counted further), then goes to RB_DONE. mismatch_cnt ends at 1.
- Undefined: all RCC_Words_N beats are always read and every mismatch is counted.

Decomposition:
- Add to ahb3lite_pkg:
  - Readback_state enum (RB_IDLE, RB_XFER, RB_LAST, RB_DONE).
  - HBURST_INCR and HSIZE_WORD localparams.
  - Reuse the existing HTRANS_state.
- One sub-module is natural: ahb_rb_addr_gen. It produces HADDR/HTRANS, the beat counter and the boundary detection. The parent keeps the FSM, data check and status.

Test Plan:
- Zero-wait read, N=4, base 0x0000_1000, init 0x10, memory 0x10..0x13 -> HADDR 0x1000/4/8/C, NONSEQ,SEQ,SEQ,SEQ, mismatch_cnt=0, done after 6 cycles.
- Corrupt word 2 (0x99) -> mismatch_cnt=1, first_err_addr=0x0000_1008, all 4 beats still issued.
- HREADY low 3 cycles on beat 1, N=3 -> HADDR/HTRANS held, checks still pass, done delayed by 3 cycles.
- Base 0x0000_03F8, N=4 -> HTRANS NONSEQ,SEQ,NONSEQ(0x400),SEQ.
- ERROR response on beat 1, N=5 -> HTRANS=IDLE in cycle 1 of the error, bus_error=1, done pulses, no further beats.
- N=0 start -> done next cycle, HTRANS stays IDLE.
- Reset mid-burst -> all outputs at reset values next cycle, no done.
- start asserted while busy -> ignored.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb3lite_pkg: shared AHB-Lite transfer types and readback checker states.
// Rev 1.0
// ----------------------------------------------------------------------------
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [1:0] {
    RB_IDLE = 2'b00,
    RB_XFER = 2'b01,
    RB_LAST = 2'b10,
    RB_DONE = 2'b11
  } Readback_state;

  localparam logic [2:0] HBURST_INCR = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/ahb_rb_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_rb_addr_gen: address-phase generator (HADDR/HTRANS, beat count, 1KB split).
// Rev 1.0
// ----------------------------------------------------------------------------
module ahb_rb_addr_gen
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_STEP      = 4,
  parameter int BOUNDARY_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] base_i,
  input  logic        active_i,
  input  logic        ready_i,
  output logic [31:0] haddr_o,
  output HTRANS_state htrans_o,
  output logic        accept_o,
  output logic [5:0]  addr_cnt_o,
  output logic [31:0] daddr_o
);

  localparam int          c_bnd_bits = $clog2(BOUNDARY_BYTES);
  localparam logic [31:0] c_step     = 32'(ADDR_STEP);

  logic [31:0] haddr_q, haddr_d;
  logic [31:0] daddr_q, daddr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        w_boundary;

  assign w_boundary = (haddr_q[c_bnd_bits-1:0] == '0);
  assign accept_o   = active_i & ready_i;
  assign haddr_o    = haddr_q;
  assign addr_cnt_o = cnt_q;
  assign daddr_o    = daddr_q;

  // An INCR burst may not cross the boundary, so the first beat past it restarts.
  always_comb begin
    htrans_o = IDLE;
    if (active_i) begin
      htrans_o = ((cnt_q == 6'd0) || w_boundary) ? NONSEQ : SEQ;
    end
  end

  always_comb begin
    haddr_d = haddr_q;
    daddr_d = daddr_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      haddr_d = base_i;
      cnt_d   = 6'd0;
    end else if (accept_o) begin
      haddr_d = haddr_q + c_step;
      daddr_d = haddr_q;
      cnt_d   = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      haddr_q <= 32'd0;
      daddr_q <= 32'd0;
      cnt_q   <= 6'd0;
    end else begin
      haddr_q <= haddr_d;
      daddr_q <= daddr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_readback_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_readback_checker: AHB-Lite read master checking an incrementing pattern.
// Optional macro RB_STOP_ON_MISMATCH_EN halts the job at the first bad beat.
// Rev 1.0
// ----------------------------------------------------------------------------
module ahb_readback_checker
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_STEP      = 4,
  parameter int BOUNDARY_BYTES = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [5:0]  RCC_Words_N,
  input  logic [15:0] RCC_DMA_ADDR_HIGH,
  input  logic [15:0] RCC_DMA_ADDR_LOW,
  input  logic [31:0] init_data,
  output logic [31:0] HADDR,
  output HTRANS_state HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic        busy,
  output logic        done,
  output logic [5:0]  mismatch_cnt,
  output logic [31:0] first_err_addr,
  output logic        bus_error
);

  Readback_state state_q, state_d;
  logic [5:0]    words_q;
  logic [31:0]   init_q;
  logic [5:0]    data_cnt_q;
  logic          dphase_q;
  logic [5:0]    mis_cnt_q;
  logic [31:0]   first_err_q;
  logic          bus_err_q;
  logic          busy_q;
  logic          done_q;

  logic          w_load;
  logic          w_active;
  logic          w_accept;
  logic          w_last_addr;
  logic          w_check;
  logic          w_err;
  logic          w_mis;
  logic          w_halted;
  logic [5:0]    w_addr_cnt;
  logic [31:0]   w_daddr;
  logic [31:0]   w_expected;

`ifdef RB_STOP_ON_MISMATCH_EN
  logic halt_q;
  assign w_halted = halt_q;
`else
  assign w_halted = 1'b0;
`endif

  assign w_load = (state_q == RB_IDLE) && start;
  // An ERROR response cancels the pending address phase in its first cycle.
  assign w_active    = (state_q == RB_XFER) && !HRESP;
  assign w_last_addr = w_accept && (w_addr_cnt == (words_q - 6'd1));
  assign w_check     = dphase_q && HREADY && !HRESP && !w_halted;
  assign w_err       = dphase_q && HREADY && HRESP;
  assign w_expected  = init_q + {26'd0, data_cnt_q};
  assign w_mis       = w_check && (HRDATA != w_expected);

  ahb_rb_addr_gen #(
    .ADDR_STEP      (ADDR_STEP),
    .BOUNDARY_BYTES (BOUNDARY_BYTES)
  ) u_addr_gen (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .load_i     (w_load),
    .base_i     ({RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW}),
    .active_i   (w_active),
    .ready_i    (HREADY),
    .haddr_o    (HADDR),
    .htrans_o   (HTRANS),
    .accept_o   (w_accept),
    .addr_cnt_o (w_addr_cnt),
    .daddr_o    (w_daddr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RB_IDLE: begin
        if (start) state_d = (RCC_Words_N == 6'd0) ? RB_DONE : RB_XFER;
      end
      RB_XFER: begin
        if (w_err)            state_d = RB_DONE;
        else if (w_last_addr) state_d = RB_LAST;
`ifdef RB_STOP_ON_MISMATCH_EN
        else if (w_mis)       state_d = RB_LAST;
`endif
      end
      RB_LAST: begin
        if (HREADY) state_d = RB_DONE;
      end
      RB_DONE: state_d = RB_IDLE;
      default: state_d = RB_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= RB_IDLE;
      words_q     <= 6'd0;
      init_q      <= 32'd0;
      data_cnt_q  <= 6'd0;
      dphase_q    <= 1'b0;
      mis_cnt_q   <= 6'd0;
      first_err_q <= 32'd0;
      bus_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RB_XFER) || (state_d == RB_LAST);
      done_q  <= (state_d == RB_DONE);
      if (w_load) begin
        words_q     <= RCC_Words_N;
        init_q      <= init_data;
        data_cnt_q  <= 6'd0;
        dphase_q    <= 1'b0;
        mis_cnt_q   <= 6'd0;
        first_err_q <= 32'd0;
        bus_err_q   <= 1'b0;
      end else begin
        if (HREADY) dphase_q <= w_accept;
        if (w_check) data_cnt_q <= data_cnt_q + 6'd1;
        if (w_mis) begin
          if (mis_cnt_q != 6'd63) mis_cnt_q <= mis_cnt_q + 6'd1;
          if (mis_cnt_q == 6'd0)  first_err_q <= w_daddr;
        end
        if (w_err) bus_err_q <= 1'b1;
      end
    end
  end

`ifdef RB_STOP_ON_MISMATCH_EN
  always_ff @(posedge HCLK) begin
    if (HRESET || w_load) halt_q <= 1'b0;
    else if (w_mis)       halt_q <= 1'b1;
  end
`endif

  assign HWRITE         = 1'b0;
  assign HSIZE          = HSIZE_WORD;
  assign HBURST         = HBURST_INCR;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch_cnt   = mis_cnt_q;
  assign first_err_addr = first_err_q;
  assign bus_error      = bus_err_q;

endmodule
`default_nettype wire
